// File: rtl/stream_demultiplexer.sv
// rtl/stream_demultiplexer.sv - 1-to-4 stream demultiplexer with a per-channel FIFO
//
// Steers each accepted input word to one of four channel FIFOs, chosen by {addr0, addr1}.
// Each channel drains through its own valid/ready handshake, so a stalled consumer
// backs up only its own channel.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   addr0, addr1        channel select, index = {addr0, addr1}
//   in_data/valid/ready input stream; in_ready = selected channel not full
//   outN, validN        head word and non-empty flag of channel N FIFO
//   readyN              consumer N takes its head word
//   busy                at least one channel FIFO holds a word

module stream_demultiplexer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             addr0,
    input  logic             addr1,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             valid0,
    output logic             valid1,
    output logic             valid2,
    output logic             valid3,
    input  logic             ready0,
    input  logic             ready1,
    input  logic             ready2,
    input  logic             ready3,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [4][DEPTH];
    logic [PW-1:0]    wptr_q [4];
    logic [PW-1:0]    wptr_d [4];
    logic [PW-1:0]    rptr_q [4];
    logic [PW-1:0]    rptr_d [4];
    logic [CW-1:0]    cnt_q  [4];
    logic [CW-1:0]    cnt_d  [4];

    logic [1:0] sel;
    logic [3:0] full;
    logic [3:0] nonempty;
    logic [3:0] push;
    logic [3:0] pop;
    logic [3:0] ready_v;

    assign sel     = {addr0, addr1};
    assign ready_v = {ready3, ready2, ready1, ready0};

    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int c = 0; c < 4; c++) begin
            full[c]     = (cnt_q[c] == FULL_CNT);
            nonempty[c] = (cnt_q[c] != '0);
        end
    end

    // Depends only on the select and registered counts: no path from readyN or in_valid.
    // Held low during reset so nothing is offered to the producer then.
    assign in_ready = rst_n & ~full[sel];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < 4; c++) begin
            push[c]   = in_valid && in_ready && (sel == 2'(c));
            pop[c]    = nonempty[c] && ready_v[c];
            // Pointers wrap naturally because DEPTH is a power of two.
            wptr_d[c] = wptr_q[c] + PW'(push[c]);
            rptr_d[c] = rptr_q[c] + PW'(pop[c]);
            // A push is never accepted when full and a pop never happens when
            // empty, so the count stays within 0..DEPTH.
            cnt_d[c]  = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
                if (push[c]) begin
                    mem_q[c][wptr_q[c]] <= in_data;
                end
            end
        end
    end

    assign out0   = mem_q[0][rptr_q[0]];
    assign out1   = mem_q[1][rptr_q[1]];
    assign out2   = mem_q[2][rptr_q[2]];
    assign out3   = mem_q[3][rptr_q[3]];
    assign valid0 = nonempty[0];
    assign valid1 = nonempty[1];
    assign valid2 = nonempty[2];
    assign valid3 = nonempty[3];
    // Derived purely from the registered counts.
    assign busy   = |nonempty;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb/tb_stream_demultiplexer.sv - directed bench for stream_demultiplexer

module tb_stream_demultiplexer;

    logic       clk;
    logic       rst_n;
    logic       addr0;
    logic       addr1;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0, out1, out2, out3;
    logic       valid0, valid1, valid2, valid3;
    logic       ready0, ready1, ready2, ready3;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wire [3:0] vld = {valid3, valid2, valid1, valid0};

    stream_demultiplexer #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .addr0(addr0), .addr1(addr1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
        .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] out_of(input int n);
        case (n)
            0: return out0;
            1: return out1;
            2: return out2;
            default: return out3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int n);
        addr0 = n[1];
        addr1 = n[0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr0 = 0; addr1 = 0; in_data = 8'h00; in_valid = 0;
        ready0 = 0; ready1 = 0; ready2 = 0; ready3 = 0;
        #12;
        total_cnt++;
        if (vld !== 4'b0000) $display("FAIL reset_valid: got %b want 0000", vld); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++;
        if ({out0, out1, out2, out3} !== 32'h0) $display("FAIL reset_out: got %h want 0", {out0, out1, out2, out3}); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else pass_cnt++;
        tick();
    endtask

    task automatic test_routing();
        ready0 = 1; ready1 = 1; ready2 = 1; ready3 = 1;
        for (int n = 0; n < 4; n++) begin
            set_sel(n);
            in_data  = 8'hA0 + 8'(n);
            in_valid = 1;
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL route_in_ready%0d: got %b want 1", n, in_ready); else pass_cnt++;
            tick();
            in_valid = 0;
            total_cnt++;
            if (vld !== 4'(1 << n)) $display("FAIL route_valid%0d: got %b want %b", n, vld, 4'(1 << n)); else pass_cnt++;
            total_cnt++;
            if (out_of(n) !== 8'hA0 + 8'(n)) $display("FAIL route_data%0d: got %h want %h", n, out_of(n), 8'hA0 + 8'(n)); else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL route_busy%0d: got %b want 1", n, busy); else pass_cnt++;
            tick();
            total_cnt++;
            if (vld !== 4'b0000) $display("FAIL route_drained%0d: got %b want 0000", n, vld); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        ready2 = 0;
        set_sel(2);
        in_valid = 1;
        in_data  = 8'h11;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_empty: got %b want 1", in_ready); else pass_cnt++;
        tick();
        in_data = 8'h22;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", in_ready); else pass_cnt++;
        tick();
        in_data = 8'h33;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else pass_cnt++;
        tick();
        in_valid = 0;
        ready2   = 1;
        total_cnt++;
        if (out2 !== 8'h11 || valid2 !== 1'b1) $display("FAIL bp_head1: got %h/%b want 11/1", out2, valid2); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_still_full: got %b want 0", in_ready); else pass_cnt++;
        tick();
        total_cnt++;
        if (out2 !== 8'h22 || valid2 !== 1'b1) $display("FAIL bp_head2: got %h/%b want 22/1", out2, valid2); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++;
        if (vld !== 4'b0000 || busy !== 1'b0) $display("FAIL bp_empty: got %b/%b want 0000/0", vld, busy); else pass_cnt++;
    endtask

    task automatic test_isolation();
        ready2 = 0;
        ready1 = 1;
        set_sel(2);
        in_valid = 1;
        in_data  = 8'h44;
        tick();
        in_data = 8'h55;
        tick();
        set_sel(1);
        in_data = 8'h61;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL iso_ready_ch1: got %b want 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 0;
        total_cnt++;
        if (out1 !== 8'h61 || valid1 !== 1'b1) $display("FAIL iso_ch1_a: got %h/%b want 61/1", out1, valid1); else pass_cnt++;
        set_sel(2);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL iso_ready_ch2: got %b want 0", in_ready); else pass_cnt++;
        tick();
        set_sel(1);
        in_valid = 1;
        in_data  = 8'h62;
        tick();
        in_valid = 0;
        total_cnt++;
        if (out1 !== 8'h62 || valid1 !== 1'b1) $display("FAIL iso_ch1_b: got %h/%b want 62/1", out1, valid1); else pass_cnt++;
        ready2 = 1;
        total_cnt++;
        if (out2 !== 8'h44 || valid2 !== 1'b1) $display("FAIL iso_ch2_a: got %h/%b want 44/1", out2, valid2); else pass_cnt++;
        tick();
        total_cnt++;
        if (out2 !== 8'h55 || valid2 !== 1'b1) $display("FAIL iso_ch2_b: got %h/%b want 55/1", out2, valid2); else pass_cnt++;
        tick();
        total_cnt++;
        if (vld !== 4'b0000) $display("FAIL iso_empty: got %b want 0000", vld); else pass_cnt++;
    endtask

    task automatic test_push_pop_same();
        ready3 = 0;
        set_sel(3);
        in_valid = 1;
        in_data  = 8'h3C;
        tick();
        in_data = 8'h5A;
        ready3  = 1;
        total_cnt++;
        if (out3 !== 8'h3C || valid3 !== 1'b1) $display("FAIL pp_head: got %h/%b want 3C/1", out3, valid3); else pass_cnt++;
        tick();
        in_valid = 0;
        ready3   = 0;
        total_cnt++;
        if (out3 !== 8'h5A || valid3 !== 1'b1) $display("FAIL pp_after: got %h/%b want 5A/1", out3, valid3); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL pp_count_one: got %b want 1", in_ready); else pass_cnt++;
        in_valid = 1;
        in_data  = 8'h77;
        tick();
        in_valid = 0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL pp_now_full: got %b want 0", in_ready); else pass_cnt++;
        ready3 = 1;
        tick();
        total_cnt++;
        if (out3 !== 8'h77 || valid3 !== 1'b1) $display("FAIL pp_second: got %h/%b want 77/1", out3, valid3); else pass_cnt++;
        tick();
        total_cnt++;
        if (valid3 !== 1'b0) $display("FAIL pp_empty: got %b want 0", valid3); else pass_cnt++;
    endtask

    task automatic test_wrap();
        ready0 = 1;
        set_sel(0);
        in_valid = 1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(k);
            tick();
            total_cnt++;
            if (out0 !== 8'(k) || valid0 !== 1'b1) $display("FAIL wrap_word%0d: got %h/%b want %h/1", k, out0, valid0, 8'(k)); else pass_cnt++;
        end
        in_valid = 0;
        tick();
        total_cnt++;
        if (valid0 !== 1'b0) $display("FAIL wrap_empty: got %b want 0", valid0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ready0 = 0; ready1 = 0; ready2 = 0; ready3 = 0;
        in_valid = 1;
        set_sel(1);
        in_data = 8'h81;
        tick();
        in_data = 8'h82;
        tick();
        set_sel(3);
        in_data = 8'h93;
        tick();
        in_valid = 0;
        set_sel(1);
        total_cnt++;
        if (vld !== 4'b1010 || busy !== 1'b1) $display("FAIL rm_loaded: got %b/%b want 1010/1", vld, busy); else pass_cnt++;
        rst_n = 0;
        #1;
        total_cnt++;
        if (vld !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL rm_in_reset: got %b/%b/%b want 0000/0/0", vld, busy, in_ready); else pass_cnt++;
        #1;
        rst_n = 1;
        in_valid = 1;
        in_data  = 8'h7E;
        tick();
        in_valid = 0;
        total_cnt++;
        if (out1 !== 8'h7E || vld !== 4'b0010) $display("FAIL rm_first: got %h/%b want 7E/0010", out1, vld); else pass_cnt++;
        ready1 = 1;
        tick();
        total_cnt++;
        if (vld !== 4'b0000) $display("FAIL rm_no_stale: got %b want 0000", vld); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_isolation();
        test_push_pop_same();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
